emu_ckpt_sched: RTL and testbench

- Autonomous periodic checkpoint scheduler for the emulation controller.
- Counts model ticks while the model runs; every programmed interval it pauses the model, enters scan mode, launches a scan-chain DMA save into a ring of checkpoint slots in "mem" space, then resumes the model.
- Sits beside the host control register file and the scan-chain DMA controller, and arbitrates run/scan control with host software writes.

---
 rtl/emu_ckpt_pkg.sv | 8 +
 rtl/emu_ckpt_interval_cnt.sv | 16 +
 rtl/emu_ckpt_sched.sv | 99 +++++++++
 tb/tb_emu_ckpt_sched.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/emu_ckpt_pkg.sv
// emu_ckpt_pkg: shared state encoding and constants for the checkpoint scheduler
package emu_ckpt_pkg;
  typedef enum logic [3:0] {
    IDLE, COUNT, PAUSE, WAIT_IDLE, SCAN, START, DMA_RISE, DMA_FALL, RESUME
  } state_t;
  localparam logic [31:0] SLOT_BYTES_DFLT = 32'h1000;
  localparam logic        DIR_SAVE        = 1'b0;
endpackage

// File: rtl/emu_ckpt_interval_cnt.sv
// emu_ckpt_interval_cnt: model-tick counter with terminal-count detect
module emu_ckpt_interval_cnt import emu_ckpt_pkg::*; (
  input  logic        host_clk,
  input  logic        host_rst_n,
  input  logic        clr,
  input  logic        inc,
  input  logic [31:0] interval,
  output logic        hit
);
  logic [31:0] cnt;
  assign hit = inc && (cnt == interval - 32'd1);
  always_ff @(posedge host_clk or negedge host_rst_n)
    if (!host_rst_n) cnt <= '0;
    else if (clr || hit) cnt <= '0;
    else if (inc) cnt <= cnt + 32'd1;
endmodule

// File: rtl/emu_ckpt_sched.sv
// emu_ckpt_sched: periodic pause/scan/DMA-save checkpoint scheduler.
// Define EMU_CKPT_SCHED_TIMEOUT_EN to add a DMA watchdog that sets sticky ckpt_err.
module emu_ckpt_sched import emu_ckpt_pkg::*; #(
  parameter int          SLOT_COUNT     = 4,
  parameter logic [31:0] SLOT_BYTES     = SLOT_BYTES_DFLT,
  parameter int          ADDR_WIDTH     = 32,
  parameter int          TIMEOUT_CYCLES = 1048576,
  localparam int         SW             = $clog2(SLOT_COUNT)
) (
  input  logic                  host_clk,
  input  logic                  host_rst_n,
  input  logic                  cfg_en,
  input  logic [31:0]           cfg_interval,
  input  logic [ADDR_WIDTH-1:0] cfg_base,
  input  logic                  tick,
  input  logic                  run_mode,
  input  logic                  model_busy,
  input  logic                  dma_running,
  output logic                  pause_req,
  output logic                  run_req,
  output logic                  scan_mode_req,
  output logic                  dma_start,
  output logic                  dma_direction,
  output logic [ADDR_WIDTH-1:0] dma_base_addr,
  output logic                  ckpt_busy,
  output logic [SW-1:0]         ckpt_slot,
  output logic [31:0]           ckpt_done_cnt,
  output logic                  ckpt_err
);
  localparam logic [ADDR_WIDTH-1:0] STRIDE = ADDR_WIDTH'(SLOT_BYTES);
  state_t state, state_nxt;
  logic go, hit, expired, tmo;
  assign go = cfg_en && (cfg_interval != '0);
  emu_ckpt_interval_cnt u_cnt (
    .host_clk   (host_clk),
    .host_rst_n (host_rst_n),
    .clr        (state != COUNT || !go),
    .inc        (state == COUNT && run_mode && tick),
    .interval   (cfg_interval),
    .hit        (hit)
  );
`ifdef EMU_CKPT_SCHED_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmr;
  logic dma_wait;
  assign dma_wait = (state == DMA_RISE) || (state == DMA_FALL);
  assign expired  = dma_wait && (tmr == TW'(TIMEOUT_CYCLES - 1));
  // tmo remembers that the current RESUME came from a watchdog expiry
  always_ff @(posedge host_clk or negedge host_rst_n)
    if (!host_rst_n) begin
      tmr      <= '0;
      tmo      <= 1'b0;
      ckpt_err <= 1'b0;
    end else begin
      tmr      <= dma_wait ? tmr + TW'(1) : '0;
      tmo      <= expired || (tmo && state != RESUME);
      ckpt_err <= ckpt_err || expired;
    end
`else
  assign expired  = 1'b0;
  assign tmo      = 1'b0;
  assign ckpt_err = 1'b0;
`endif
  always_ff @(posedge host_clk or negedge host_rst_n)
    if (!host_rst_n) begin
      state         <= IDLE;
      ckpt_slot     <= '0;
      ckpt_done_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == RESUME && !tmo) begin
        ckpt_slot     <= ckpt_slot + SW'(1);
        ckpt_done_cnt <= ckpt_done_cnt + 32'd1;
      end
    end
  // once PAUSE is entered the sequence runs to RESUME regardless of cfg_en
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      state_nxt = go ? COUNT : IDLE;
      COUNT:     state_nxt = !go ? IDLE : hit ? PAUSE : COUNT;
      PAUSE:     state_nxt = WAIT_IDLE;
      WAIT_IDLE: state_nxt = (!run_mode && !model_busy) ? SCAN : WAIT_IDLE;
      SCAN:      state_nxt = START;
      START:     state_nxt = DMA_RISE;
      DMA_RISE:  state_nxt = expired ? RESUME : dma_running ? DMA_FALL : DMA_RISE;
      DMA_FALL:  state_nxt = (expired || !dma_running) ? RESUME : DMA_FALL;
      RESUME:    state_nxt = cfg_en ? COUNT : IDLE;
      default:   state_nxt = IDLE;
    endcase
  end
  assign pause_req     = state == PAUSE;
  assign run_req       = state == RESUME;
  assign dma_start     = state == START;
  assign scan_mode_req = state == SCAN || state == START || state == DMA_RISE || state == DMA_FALL;
  assign ckpt_busy     = state != IDLE && state != COUNT;
  assign dma_direction = DIR_SAVE;
  assign dma_base_addr = cfg_base + STRIDE * ADDR_WIDTH'(ckpt_slot);
endmodule

// File: tb/tb_emu_ckpt_sched.sv
// tb_emu_ckpt_sched: scoreboard bench with a model/DMA environment around the scheduler
module tb_emu_ckpt_sched;
  localparam int EV_P = 0, EV_S = 1, EV_R = 2;
  localparam logic [31:0] BASE = 32'h8000_0000;
  typedef struct {int kind; logic [31:0] a; logic [31:0] b;} ev_t;
  logic host_clk, host_rst_n, cfg_en, tick, run_mode, model_busy, dma_running;
  logic [31:0] cfg_interval, cfg_base, dma_base_addr, ckpt_done_cnt;
  logic pause_req, run_req, scan_mode_req, dma_start, dma_direction, ckpt_busy, ckpt_err;
  logic [1:0] ckpt_slot;
  logic model_run, host_hold;
  int busy_hold, busy_cnt, dma_delay, dma_len, dma_never, dcnt;
  int total, passed;
  ev_t q[$];
  emu_ckpt_sched #(.SLOT_COUNT(4), .SLOT_BYTES(32'h1000), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(64)) dut (
    .host_clk(host_clk), .host_rst_n(host_rst_n), .cfg_en(cfg_en), .cfg_interval(cfg_interval),
    .cfg_base(cfg_base), .tick(tick), .run_mode(run_mode), .model_busy(model_busy),
    .dma_running(dma_running), .pause_req(pause_req), .run_req(run_req),
    .scan_mode_req(scan_mode_req), .dma_start(dma_start), .dma_direction(dma_direction),
    .dma_base_addr(dma_base_addr), .ckpt_busy(ckpt_busy), .ckpt_slot(ckpt_slot),
    .ckpt_done_cnt(ckpt_done_cnt), .ckpt_err(ckpt_err)
  );
  assign run_mode = model_run && !host_hold;
  initial host_clk = 1'b0;
  always #5 host_clk = ~host_clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask
  task automatic step();
    @(posedge host_clk); #1;
  endtask
  task automatic push(input int k, input logic [31:0] a, input logic [31:0] b);
    ev_t e;
    e.kind = k; e.a = a; e.b = b;
    q.push_back(e);
  endtask
  task automatic ckpt(input int slot, input int done);
    push(EV_P, slot, done);
    push(EV_S, BASE + 32'(slot) * 32'h1000, 0);
    push(EV_R, done + 1, (slot + 1) % 4);
  endtask
  task automatic expect_ev(input int k, input logic [31:0] a, input logic [31:0] b);
    ev_t e;
    if (q.size() == 0) begin
      total++;
      $display("FAIL unexpected_event: got kind %0d a=%0h b=%0h expected no event", k, a, b);
    end else begin
      e = q.pop_front();
      chk("ev_kind", k, e.kind);
      chk("ev_a", a, e.a);
      chk("ev_b", b, e.b);
    end
  endtask
  task automatic wait_done(input int target, input string nm);
    int i = 0;
    while (ckpt_done_cnt != target && i < 2000) begin step(); i++; end
    chk(nm, ckpt_done_cnt, target);
  endtask
  // environment: model honours pause/run requests, DMA answers dma_start
  initial begin
    model_run = 1'b1; model_busy = 1'b0; dma_running = 1'b0; busy_cnt = 0; dcnt = 0;
    forever begin
      @(posedge host_clk); #2;
      if (pause_req) begin model_run = 1'b0; busy_cnt = busy_hold; end
      else if (busy_cnt > 0) busy_cnt--;
      if (run_req) model_run = 1'b1;
      if (dma_start && dma_never == 0) dcnt = dma_delay + dma_len;
      else if (dcnt > 0) dcnt--;
      model_busy  = busy_cnt != 0;
      dma_running = dcnt != 0 && dcnt <= dma_len;
    end
  end
  // monitor: resume checks look at slot/count the cycle after run_req
  initial forever begin
    @(negedge host_clk);
    if (host_rst_n) begin
      if (pause_req) expect_ev(EV_P, ckpt_slot, ckpt_done_cnt);
      if (dma_start) expect_ev(EV_S, dma_base_addr, dma_direction);
      if (run_req) begin
        @(negedge host_clk);
        expect_ev(EV_R, ckpt_done_cnt, ckpt_slot);
      end
    end
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1);
  end
  initial begin
    int n, b, s, early, pc;
    total = 0; passed = 0;
    host_rst_n = 1'b0; cfg_en = 1'b0; cfg_interval = 3; cfg_base = BASE; tick = 1'b0;
    host_hold = 1'b0; busy_hold = 0; dma_delay = 10; dma_len = 3; dma_never = 0;
    repeat (3) @(posedge host_clk);
    #1;
    chk("rst_pause", pause_req, 0);
    chk("rst_run", run_req, 0);
    chk("rst_scan", scan_mode_req, 0);
    chk("rst_start", dma_start, 0);
    chk("rst_slot", ckpt_slot, 0);
    chk("rst_done", ckpt_done_cnt, 0);
    chk("rst_busy", ckpt_busy, 0);
    chk("rst_err", ckpt_err, 0);
    chk("rst_addr", dma_base_addr, BASE);
    host_rst_n = 1'b1;
    step();
    // first checkpoint, interval 3
    ckpt(0, 0);
    cfg_en = 1'b1;
    step();
    tick = 1'b1;
    step(); step();
    chk("t1_no_early_pause", pause_req, 0);
    step();
    chk("t1_pause", pause_req, 1);
    tick = 1'b0;
    n = 0;
    while (!dma_start && n < 20) begin step(); n++; end
    chk("t1_pause_to_start", n, 3);
    chk("t1_base", dma_base_addr, BASE);
    wait_done(1, "t1_done");
    chk("t1_slot", ckpt_slot, 1);
    // four more checkpoints walk the ring and wrap
    for (int k = 1; k < 5; k++) ckpt(k % 4, k);
    tick = 1'b1;
    wait_done(5, "t2_done");
    cfg_en = 1'b0; tick = 1'b0;
    step();
    chk("t2_slot", ckpt_slot, 1);
    // model stays busy 20 cycles after pausing
    busy_hold = 20;
    ckpt(1, 5);
    cfg_en = 1'b1; tick = 1'b1;
    n = 0;
    while (!pause_req && n < 50) begin step(); n++; end
    chk("t3_pause_seen", pause_req, 1);
    tick = 1'b0;
    b = -1; s = -1; early = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge host_clk);
      if (b < 0 && !model_busy) b = i;
      if (dma_start) early = 1;
      if (scan_mode_req) begin s = i; break; end
    end
    chk("t3_scan_after_busy", s, b + 1);
    chk("t3_no_early_start", early, 0);
    busy_hold = 0;
    wait_done(6, "t3_done");
    cfg_en = 1'b0;
    step();
    // cfg_en dropped while waiting for DMA to finish
    ckpt(2, 6);
    cfg_en = 1'b1; tick = 1'b1;
    n = 0;
    while (!dma_running && n < 100) begin step(); n++; end
    chk("t4_dma_seen", dma_running, 1);
    cfg_en = 1'b0;
    wait_done(7, "t4_done");
    chk("t4_idle", ckpt_busy, 0);
    pc = 0;
    for (int i = 0; i < 100; i++) begin step(); if (pause_req) pc++; end
    chk("t4_no_pause", pc, 0);
    tick = 1'b0;
    // host holds the model paused mid-interval
    cfg_interval = 10;
    ckpt(3, 7);
    cfg_en = 1'b1;
    step();
    tick = 1'b1;
    repeat (4) step();
    host_hold = 1'b1;
    repeat (50) step();
    chk("t5_held", pause_req, 0);
    host_hold = 1'b0;
    repeat (5) step();
    chk("t5_no_early_pause", pause_req, 0);
    step();
    chk("t5_trigger", pause_req, 1);
    tick = 1'b0;
    wait_done(8, "t5_done");
    cfg_en = 1'b0;
    step();
`ifdef EMU_CKPT_SCHED_TIMEOUT_EN
    // DMA never starts: watchdog expires after 64 cycles in the DMA wait states
    cfg_interval = 3; dma_never = 1;
    push(EV_P, 0, 8);
    push(EV_S, BASE, 0);
    push(EV_R, 8, 0);
    cfg_en = 1'b1; tick = 1'b1;
    n = 0;
    while (!dma_start && n < 50) begin step(); n++; end
    chk("t6_start", dma_start, 1);
    tick = 1'b0; cfg_en = 1'b0;
    n = 0;
    while (!ckpt_err && n < 200) begin step(); n++; end
    chk("t6_err_cycle", n, 65);
    chk("t6_run_req", run_req, 1);
    step();
    chk("t6_slot", ckpt_slot, 0);
    chk("t6_done", ckpt_done_cnt, 8);
    dma_never = 0;
`else
    chk("no_err", ckpt_err, 0);
`endif
    repeat (3) step();
    chk("sb_empty", q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
